// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester (I)
// and the data load/store requester (D). A granted request is latched, issued
// to memory for exactly one cycle, and the arbiter then waits for mem_valid.
// Completion is a one-cycle done pulse on the owning port. Hung accesses
// complete with err after TIMEOUT wait cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (level) and address
//   if_rdata/if_done         fetched word, fetch completion pulse
//   d_req/d_wr/d_addr/d_wdata data request (level), store flag, address, data
//   d_rdata/d_done           load data, data completion pulse
//   mem_en/mem_wr            memory strobe (one cycle per access), write enable
//   mem_addr/mem_wdata       latched address / write data
//   mem_rdata/mem_valid      memory read data, read-valid / write-ack
//   err                      pulses with done when the access timed out
//   stall                    a request is pending and not completing this cycle
//
// state  | meaning
// IDLE   | arbitrate between if_req and d_req, latch the winner
// ISSUE  | mem_en for one cycle, clear wait counter
// WAIT   | wait for mem_valid or timeout
// DONE   | done (and err) pulse to owner, record last grant
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              err,
    output logic              stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The counter holds the number of WAIT cycles already spent without
    // mem_valid; once it would reach TIMEOUT the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic              lat_wr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              timed_out_q;

    logic grant;
    logic grant_own;
    logic wait_hit;
    logic wait_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_own   = owner_q;
        wait_hit    = 1'b0;
        wait_expire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    grant = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    if (if_req && d_req) begin
                        grant_own = ~last_grant_q;
                    end else begin
                        grant_own = d_req ? OWN_D : OWN_I;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid) begin
                    wait_hit = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    wait_expire = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            cnt_q        <= '0;
            lat_addr_q   <= '0;
            lat_wr_q     <= 1'b0;
            lat_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            if (grant) begin
                owner_q     <= grant_own;
                lat_addr_q  <= (grant_own == OWN_D) ? d_addr : if_addr;
                lat_wr_q    <= (grant_own == OWN_D) & d_wr;
                lat_wdata_q <= (grant_own == OWN_D) ? d_wdata : '0;
                timed_out_q <= 1'b0;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end
            if (wait_hit) begin
                if (!lat_wr_q) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_q <= mem_rdata;
                    end else begin
                        if_rdata_q <= mem_rdata;
                    end
                end
            end else if (wait_expire) begin
                timed_out_q <= 1'b1;
                if (!lat_wr_q) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_q <= '1;
                    end else begin
                        if_rdata_q <= '1;
                    end
                end
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == S_DONE) begin
                last_grant_q <= owner_q;
            end
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_wr    = mem_en & lat_wr_q;
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = (state_q == S_DONE) & (owner_q == OWN_I);
    assign d_done   = (state_q == S_DONE) & (owner_q == OWN_D);
    assign err      = (state_q == S_DONE) & timed_out_q;

    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 16-bit memory between the instruction-fetch requester and the data-access requester (load/store) of the processor.
- Latches each granted request, drives the memory for one issue cycle, and waits for the memory's valid/ack.
- Returns read data with a one-cycle done pulse.
- Asserts stall to the pipeline/PC logic while any request is outstanding; times out hung accesses.

Parameters:
- ADDR_W, 16, address width of both requesters and memory.
- DATA_W, 16, data width.
- TIMEOUT, 15, max WAIT cycles for mem_valid before error completion (>=1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level, held until d_done.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_done  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_wr  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address, held from ISSUE through WAIT.
- mem_wdata  out  DATA_W  memory write data, held from ISSUE through WAIT.
- mem_rdata  in  DATA_W  memory read data, sampled when mem_valid=1.
- mem_valid  in  1  memory read-data-valid / write-ack.
- err  out  1  one-cycle pulse with done when the access timed out.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: owner (I/D), last_grant (I/D), wait counter.
- IDLE:
  - Only d_req -> owner=D.
  - Only if_req -> owner=I.
  - Both -> owner = requester not equal to last_grant (round-robin).
  - Neither -> stay IDLE.
  - On grant: latch addr, wr (0 for I), wdata; go ISSUE.
- ISSUE, 1 cycle:
  - mem_en=1; mem_wr = latched wr; clear wait counter; go WAIT.
  - mem_valid in ISSUE is ignored.
- WAIT:
  - mem_valid=1 -> if owner's access is a read, latch mem_rdata into owner's rdata; go DONE.
  - Else counter increments; when counter reaches TIMEOUT with no valid -> set rdata of owner to all-ones (reads only), flag err; go DONE.
- DONE, 1 cycle:
  - owner's done=1; err=1 if timed out.
  - last_grant=owner; go IDLE.
  - Requests are not evaluated in DONE, so the requester drops req before the next arbitration.
- Stores never modify d_rdata. if_rdata/d_rdata hold their value until the next completing read of that port.
- mem_en=0 outside ISSUE. mem_valid outside WAIT is ignored.
- Latency with a 1-cycle memory: req sampled in cycle 0, mem_en cycle 1, mem_valid cycle 2, done cycle 3, IDLE cycle 4. Back-to-back grant earliest cycle 4.
- Request inputs changing after grant do not affect the in-flight access (latched).
- Dropping req before done is illegal; the access still completes and done still pulses.
- Reset (rst=0, any state, asynchronous) returns to:
  - state IDLE, owner=I, last_grant=D;
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0;
  - if_rdata=0, d_rdata=0, if_done=0, d_done=0, err=0, counter=0.
  - Any in-flight memory response is discarded. The first tie after reset grants I.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0010, mem_valid one cycle after mem_en with rdata=0xA5A5 -> mem_en in cycle 1 with addr 0x0010, mem_wr=0; if_done and if_rdata=0xA5A5 in cycle 3; stall high cycles 0-2.
- Store: d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_en=1, mem_wr=1, mem_addr=0x0200, mem_wdata=0x1234 in cycle 1; d_done in cycle 3; d_rdata unchanged (0 after reset).
- Tie after reset: if_req=d_req=1 held -> I granted first (done cycle 3), then D granted (mem_en cycle 5). With both requesters re-requesting continuously, grants alternate I, D, I, D.
- Timeout: d_req=1 load, mem_valid never asserted -> d_done=1, err=1, d_rdata=0xFFFF exactly TIMEOUT+1 cycles after ISSUE; next request served normally.
- Reset mid-WAIT: rst=0 during WAIT, then mem_valid pulses after release -> no done pulse; outputs at reset values; state IDLE; next tie grants I.
- Stray mem_valid in IDLE and in ISSUE -> no rdata change, no done pulse.
